// File: rtl/argmax_unit.sv
// argmax_unit: scans NUM_CLASSES signed logits from the output buffer, one
// read per FETCH/CMP pair. It keeps a running maximum and publishes the
// winning class index and value with a one-cycle done pulse. The published
// result stays stable for the whole scan, so the display never shows a
// partial answer.
module argmax_unit #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int BASE_ADDR   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [3:0]            argmax_output,
  output logic [DATA_WIDTH-1:0] max_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_CMP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0]            LAST_IDX = 4'(NUM_CLASSES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  state_e                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic [3:0]                   run_arg_q, run_arg_d;
  logic signed [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [3:0]                   argmax_q, argmax_d;
  logic [DATA_WIDTH-1:0]        max_value_q, max_value_d;
  logic                         result_valid_q, result_valid_d;

  // Next-state and datapath update: compare in CMP, publish on the CMP->DONE step.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    run_arg_d      = run_arg_q;
    run_max_d      = run_max_q;
    argmax_d       = argmax_q;
    max_value_d    = max_value_q;
    result_valid_d = result_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        // Strict greater-than so ties keep the earlier (lower) class index.
        if ((idx_q == 4'd0) || ($signed(mem_rdata) > run_max_q)) begin
          run_max_d = $signed(mem_rdata);
          run_arg_d = idx_q;
        end else begin
          run_max_d = run_max_q;
          run_arg_d = run_arg_q;
        end
        if (idx_q == LAST_IDX) begin
          // Publish including the last comparison's outcome.
          state_d        = S_DONE;
          argmax_d       = run_arg_d;
          max_value_d    = run_max_d;
          result_valid_d = 1'b1;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= 4'd0;
      run_arg_q      <= 4'd0;
      run_max_q      <= '0;
      argmax_q       <= 4'd0;
      max_value_q    <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      run_arg_q      <= run_arg_d;
      run_max_q      <= run_max_d;
      argmax_q       <= argmax_d;
      max_value_q    <= max_value_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Output decode from the state register; the read address is only live in FETCH.
  always_comb begin
    mem_rd_en = (state_q == S_FETCH);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    if (state_q == S_FETCH) begin
      mem_addr = BASE + ADDR_WIDTH'(idx_q);
    end else begin
      mem_addr = BASE;
    end
  end

  assign argmax_output = argmax_q;
  assign max_value     = max_value_q;
  assign result_valid  = result_valid_q;

endmodule

// File: tb/tb_argmax_unit.sv
// Scoreboard testbench for argmax_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_argmax_unit;
  localparam int N    = 10;
  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          result_valid;
  logic [3:0]    argmax_output;
  logic [DW-1:0] max_value;

  argmax_unit #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .result_valid(result_valid),
    .argmax_output(argmax_output), .max_value(max_value)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Output buffer model: data one cycle after the read enable, junk otherwise.
  int mem [0:15];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[int'(mem_addr) - BASE];
    else           mem_rdata <= $urandom;
  end

  typedef struct { int arg; int mx; int done_cyc; } exp_t;
  exp_t sbq[$];
  exp_t e;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: find the largest value, then the first index holding it.
  task automatic ref_model(output int arg, output int mx);
    mx = mem[0];
    for (int i = 1; i < N; i++) if (mem[i] > mx) mx = mem[i];
    arg = -1;
    for (int i = N - 1; i >= 0; i--) if (mem[i] == mx) arg = i;
  endtask

  // Caller is at a negedge with the DUT idle; start is sampled at the next edge.
  task automatic issue();
    int a, m;
    ref_model(a, m);
    start = 1'b1;
    sbq.push_back('{arg: a, mx: m, done_cyc: cyc + 2*N + 1});
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got no done expected done within 200 cycles", nm);
  endtask

  task automatic load(input int v [0:9]);
    for (int i = 0; i < N; i++) mem[i] = v[i];
  endtask

  task automatic load_random();
    for (int i = 0; i < N; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 20)) - 10;
  endtask

  // Monitor model state.
  int exp_disp  = 0;
  int exp_mx    = 0;
  bit exp_rv    = 1'b0;
  int rd_cnt    = 0;
  bit mon_en    = 1'b0;
  bit prev_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mon_en    = 1'b1;
      exp_disp  = 0;
      exp_mx    = 0;
      exp_rv    = 1'b0;
      rd_cnt    = 0;
      prev_done = 1'b0;
      sbq.delete();
    end
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (prev_done) chk("busy_after_done", busy, 1'b0);
      if (mem_rd_en) begin
        chk("rd_addr", mem_addr, BASE + rd_cnt);
        rd_cnt++;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("reads_per_scan", rd_cnt, N);
          exp_disp = e.arg;
          exp_mx   = e.mx;
          exp_rv   = 1'b1;
        end
        rd_cnt = 0;
      end
      chk("argmax_output", argmax_output, exp_disp);
      chk("max_value", $signed(max_value), exp_mx);
      chk("result_valid", result_valid, exp_rv);
      prev_done = done;
    end
  end

  int v_basic [0:9] = '{5, -3, 17, 2, 9, 0, -1, 16, 4, 8};
  int v_tie   [0:9] = '{3, 7, 1, 7, 0, 0, 0, 0, 7, 2};
  int v_neg   [0:9] = '{-10, -4, -8, -100, -5, -4, -9, -20, -7, -6};
  int d1;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_argmax", argmax_output, 4'd0);
    chk("rst_max", $signed(max_value), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic scan.
    load(v_basic);
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("basic");
    chk("basic_arg", argmax_output, 2);
    chk("basic_max", $signed(max_value), 17);
    @(negedge clk);

    // Tie: lowest index wins.
    load(v_tie);
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("tie");
    chk("tie_arg", argmax_output, 1);
    chk("tie_max", $signed(max_value), 7);
    @(negedge clk);

    // All negative: signed compare.
    load(v_neg);
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("neg");
    chk("neg_arg", argmax_output, 1);
    chk("neg_max", $signed(max_value), -4);
    @(negedge clk);

    // Start held high through most of the scan: only one scan.
    load_random();
    issue();
    repeat (15) @(negedge clk);
    start = 1'b0;
    wait_done("held");
    repeat (5) @(negedge clk);
    chk("held_no_restart", busy, 1'b0);

    // Extra start pulse mid-scan is ignored.
    load_random();
    issue();
    @(negedge clk) start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done("pulse");
    @(negedge clk);

    // Rerun with logit[9]=50 back-to-back after a result of 2.
    load(v_basic);
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("rerun_a");
    d1 = cyc;
    chk("rerun_a_arg", argmax_output, 2);
    @(negedge clk);
    mem[9] = 50;
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("rerun_b");
    chk("rerun_period", cyc - d1, 2*N + 2);
    chk("rerun_b_arg", argmax_output, 9);
    @(negedge clk);

    // Random scans, back-to-back or with short idle gaps.
    for (int k = 0; k < 20; k++) begin
      load_random();
      issue();
      @(negedge clk) start = 1'b0;
      wait_done("random");
      @(negedge clk);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a scan.
    load_random();
    issue();
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rv", result_valid, 1'b0);
    chk("mid_rst_rd_en", mem_rd_en, 1'b0);
    chk("mid_rst_argmax", argmax_output, 4'd0);
    chk("mid_rst_max", $signed(max_value), 0);
    reset = 1'b0;
    @(negedge clk);
    load(v_basic);
    issue();
    @(negedge clk) start = 1'b0;
    wait_done("after_reset");
    chk("after_reset_arg", argmax_output, 2);
    chk("after_reset_max", $signed(max_value), 17);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
